// File: rtl/bp_be_fe_link.sv
// BE endpoint of the FE-BE link: fetch buffer toward issue, command FIFO toward FE, stall/flush/run tracker.
// Latency: FE enqueue -> fetch_v_o 1 cycle, cmd_i accept -> fe_cmd_v_o 1 cycle, no bypass paths.
// Backpressure: fe_queue_ready_o from state and buffer occupancy only; cmd_ready_o is command FIFO not full.
package bp_be_fe_link_pkg;
    typedef enum int unsigned {e_bp_default_cfg = 0} bp_params_e;

    localparam int vaddr_width_gp = 39;

    typedef enum logic [0:0] {e_fe_fetch = 1'b0, e_fe_exception = 1'b1} bp_fe_queue_type_e;
    typedef enum logic [1:0] {
        e_itlb_miss, e_instr_page_fault, e_instr_access_fault, e_illegal_instr
    } bp_fe_exception_code_e;
    typedef enum logic [2:0] {
        e_op_state_reset, e_op_pc_redirection, e_op_icache_fill_response,
        e_op_icache_fence, e_op_itlb_fill_response, e_op_attaboy
    } bp_fe_cmd_opcode_e;

    typedef struct packed {
        bp_fe_queue_type_e          msg_type;
        bp_fe_exception_code_e      xcpt_code;
        logic [vaddr_width_gp-1:0]  pc;
        logic [31:0]                instr;
    } bp_fe_queue_s;

    typedef struct packed {
        bp_fe_cmd_opcode_e          opcode;
        logic [vaddr_width_gp-1:0]  vaddr;
    } bp_fe_cmd_s;

    function automatic int fe_queue_width(bp_params_e cfg);
        case (cfg)
            default: return $bits(bp_fe_queue_s);
        endcase
    endfunction

    function automatic int fe_cmd_width(bp_params_e cfg);
        case (cfg)
            default: return $bits(bp_fe_cmd_s);
        endcase
    endfunction
endpackage

// Generic FIFO with synchronous clear that overrides push and pop.
// Latency: push visible at head_dat one cycle later.
// Backpressure: push ignored when full, pop ignored when empty.
module bp_be_fe_link_fifo #(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               push,
    input  logic [width_p-1:0] push_dat,
    input  logic               pop,
    output logic [width_p-1:0] head_dat,
    output logic               full,
    output logic               empty
);
    localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w = $clog2(els_p + 1);

    logic [width_p-1:0] mem [els_p];
    logic [ptr_w-1:0]   rd_ptr, wr_ptr;
    logic [cnt_w-1:0]   cnt;
    logic               push_ok, pop_ok;

    function automatic logic [ptr_w-1:0] inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(els_p - 1)) ? '0 : p + ptr_w'(1);
    endfunction

    assign full     = (cnt == cnt_w'(els_p));
    assign empty    = (cnt == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= inc(wr_ptr);
            if (pop_ok)  rd_ptr <= inc(rd_ptr);
            if (push_ok && !pop_ok)      cnt <= cnt + cnt_w'(1);
            else if (!push_ok && pop_ok) cnt <= cnt - cnt_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clr) mem[wr_ptr] <= push_dat;
    end
endmodule

// FE-BE link top: buffers FE messages, serializes BE commands, tracks FE protocol state.
// Latency: 1 cycle from either input channel to the corresponding output valid.
// Backpressure: stall/flush always accept (and discard); run accepts while the fetch buffer has room.
module bp_be_fe_link
    import bp_be_fe_link_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg,
    parameter int queue_els_p = 4,
    parameter int cmd_els_p   = 2,
    localparam int fe_queue_width_lp = fe_queue_width(bp_params_p),
    localparam int fe_cmd_width_lp   = fe_cmd_width(bp_params_p)
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [fe_queue_width_lp-1:0] fe_queue_i,
    input  logic                         fe_queue_v_i,
    output logic                         fe_queue_ready_o,
    output logic [fe_cmd_width_lp-1:0]   fe_cmd_o,
    output logic                         fe_cmd_v_o,
    input  logic                         fe_cmd_yumi_i,
    input  logic [fe_cmd_width_lp-1:0]   cmd_i,
    input  logic                         cmd_v_i,
    output logic                         cmd_ready_o,
    output logic [fe_queue_width_lp-1:0] fetch_o,
    output logic                         fetch_v_o,
    input  logic                         fetch_yumi_i,
    output logic [7:0]                   drop_cnt_o,
    output logic                         err_o
);
    localparam int pend_w = $clog2(cmd_els_p + 1);
    localparam int op_w   = $bits(bp_fe_cmd_opcode_e);
    localparam int typ_w  = $bits(bp_fe_queue_type_e);

    typedef enum logic [1:0] {e_stall, e_flush, e_run} state_e;

    state_e              state_r, state_n;
    logic [pend_w-1:0]   pend_r, pend_n;
    logic                fetch_full, fetch_empty, cmd_full, cmd_empty;
    bp_fe_cmd_opcode_e   req_op, head_op;
    bp_fe_queue_type_e   arr_type;
    logic                cmd_acc, na_acc, cmd_pop, na_pop;
    logic                arrive, drop, enq, set_err;

    // Opcode and message type are the MSB fields of their packed structs.
    assign req_op   = bp_fe_cmd_opcode_e'(cmd_i[fe_cmd_width_lp-1 -: op_w]);
    assign head_op  = bp_fe_cmd_opcode_e'(fe_cmd_o[fe_cmd_width_lp-1 -: op_w]);
    assign arr_type = bp_fe_queue_type_e'(fe_queue_i[fe_queue_width_lp-1 -: typ_w]);

    assign cmd_acc = cmd_v_i && !cmd_full;
    assign na_acc  = cmd_acc && (req_op != e_op_attaboy);
    assign cmd_pop = fe_cmd_yumi_i && !cmd_empty;
    assign na_pop  = cmd_pop && (head_op != e_op_attaboy);

    assign cmd_ready_o = !cmd_full;
    assign fe_cmd_v_o  = !cmd_empty;
    assign fetch_v_o   = !fetch_empty;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_r <= e_stall;
        else            state_r <= state_n;
    end

    always_comb begin
        pend_n = pend_r;
        if (na_acc && !na_pop)      pend_n = pend_r + pend_w'(1);
        else if (!na_acc && na_pop) pend_n = pend_r - pend_w'(1);
    end

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            e_stall: if (na_acc) state_n = e_flush;
            e_flush: if (pend_n == '0) state_n = e_run;
            e_run: begin
                if (na_acc)                                  state_n = e_flush;
                else if (enq && arr_type == e_fe_exception)  state_n = e_stall;
            end
            default: state_n = e_stall;
        endcase
    end

    // A redirect accepted in run also discards the message arriving alongside it.
    always_comb begin
        fe_queue_ready_o = (state_r != e_run) || !fetch_full;
        arrive           = fe_queue_v_i && fe_queue_ready_o;
        drop             = arrive && ((state_r != e_run) || na_acc);
        enq              = arrive && !drop;
        set_err          = arrive && (state_r == e_stall);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pend_r     <= '0;
            drop_cnt_o <= '0;
            err_o      <= 1'b0;
        end else begin
            pend_r <= pend_n;
            if (drop && drop_cnt_o != 8'hff) drop_cnt_o <= drop_cnt_o + 8'd1;
            if (set_err) err_o <= 1'b1;
        end
    end

    bp_be_fe_link_fifo #(.width_p(fe_queue_width_lp), .els_p(queue_els_p)) fetch_buf (
        .clk      (clk_i),
        .rst_n    (reset_n_i),
        .clr      (na_acc),
        .push     (enq),
        .push_dat (fe_queue_i),
        .pop      (fetch_yumi_i),
        .head_dat (fetch_o),
        .full     (fetch_full),
        .empty    (fetch_empty)
    );

    bp_be_fe_link_fifo #(.width_p(fe_cmd_width_lp), .els_p(cmd_els_p)) cmd_buf (
        .clk      (clk_i),
        .rst_n    (reset_n_i),
        .clr      (1'b0),
        .push     (cmd_v_i),
        .push_dat (cmd_i),
        .pop      (fe_cmd_yumi_i),
        .head_dat (fe_cmd_o),
        .full     (cmd_full),
        .empty    (cmd_empty)
    );
endmodule

// File: tb/tb_bp_be_fe_link.sv
// Bench for bp_be_fe_link: directed protocol scenarios plus random traffic against a queue-based model.
module tb_bp_be_fe_link;
    import bp_be_fe_link_pkg::*;

    localparam int QELS = 4;
    localparam int CELS = 2;
    localparam int QW   = $bits(bp_fe_queue_s);
    localparam int CW   = $bits(bp_fe_cmd_s);
    localparam int VW   = 1 + QW + 1 + 1 + CW + 1 + 8 + 1;
    localparam int STALL = 0, FLUSH = 1, RUN = 2;
    localparam bp_fe_queue_s NOQ = '0;
    localparam bp_fe_cmd_s   NOC = '0;

    typedef logic [VW-1:0] vec_t;

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    bp_fe_queue_s fe_queue;
    logic         fe_queue_v, fe_queue_ready;
    bp_fe_cmd_s   fe_cmd;
    logic         fe_cmd_v, fe_cmd_yumi;
    bp_fe_cmd_s   cmd;
    logic         cmd_v, cmd_ready;
    bp_fe_queue_s fetch;
    logic         fetch_v, fetch_yumi;
    logic [7:0]   drop_cnt;
    logic         err;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    bp_be_fe_link #(.bp_params_p(e_bp_default_cfg), .queue_els_p(QELS), .cmd_els_p(CELS)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .fe_queue_i(fe_queue), .fe_queue_v_i(fe_queue_v), .fe_queue_ready_o(fe_queue_ready),
        .fe_cmd_o(fe_cmd), .fe_cmd_v_o(fe_cmd_v), .fe_cmd_yumi_i(fe_cmd_yumi),
        .cmd_i(cmd), .cmd_v_i(cmd_v), .cmd_ready_o(cmd_ready),
        .fetch_o(fetch), .fetch_v_o(fetch_v), .fetch_yumi_i(fetch_yumi),
        .drop_cnt_o(drop_cnt), .err_o(err)
    );

    // Reference model: buffers as queues, protocol mode as a plain integer.
    bp_fe_queue_s fq[$];
    bp_fe_cmd_s   cq[$];
    int           m_mode = STALL;
    int           m_drop = 0;
    bit           m_err  = 1'b0;

    always @(posedge clk_i or negedge reset_n_i) begin : model
        bit rdy, arrive, acc, na, popc, deq;
        int pend;
        if (!reset_n_i) begin
            fq.delete(); cq.delete();
            m_mode = STALL; m_drop = 0; m_err = 1'b0;
        end else begin
            rdy    = (m_mode != RUN) || (fq.size() < QELS);
            arrive = fe_queue_v && rdy;
            acc    = cmd_v && (cq.size() < CELS);
            na     = acc && (cmd.opcode != e_op_attaboy);
            popc   = fe_cmd_yumi && (cq.size() > 0);
            deq    = fetch_yumi && (fq.size() > 0);
            if (popc) void'(cq.pop_front());
            if (acc) cq.push_back(cmd);
            pend = 0;
            foreach (cq[i]) if (cq[i].opcode != e_op_attaboy) pend++;
            if (deq) void'(fq.pop_front());
            case (m_mode)
                STALL: begin
                    if (arrive) begin
                        if (m_drop < 255) m_drop++;
                        m_err = 1'b1;
                    end
                    if (na) m_mode = FLUSH;
                end
                FLUSH: begin
                    if (arrive && m_drop < 255) m_drop++;
                    if (pend == 0) m_mode = RUN;
                end
                default: begin
                    if (na) begin
                        if (arrive && m_drop < 255) m_drop++;
                        m_mode = FLUSH;
                    end else if (arrive) begin
                        fq.push_back(fe_queue);
                        if (fe_queue.msg_type == e_fe_exception) m_mode = STALL;
                    end
                end
            endcase
            if (na) fq.delete();
        end
    end

    function automatic vec_t dut_vec();
        bp_fe_queue_s q;
        bp_fe_cmd_s   c;
        q = fetch_v ? fetch : NOQ;
        c = fe_cmd_v ? fe_cmd : NOC;
        return {fetch_v, q, fe_queue_ready, fe_cmd_v, c, cmd_ready, drop_cnt, err};
    endfunction

    function automatic vec_t ref_vec();
        bp_fe_queue_s q;
        bp_fe_cmd_s   c;
        logic [7:0]   d;
        q = NOQ;
        c = NOC;
        if (fq.size() > 0) q = fq[0];
        if (cq.size() > 0) c = cq[0];
        d = m_drop[7:0];
        return {fq.size() > 0, q, (m_mode != RUN) || (fq.size() < QELS),
                cq.size() > 0, c, cq.size() < CELS, d, m_err};
    endfunction

    function automatic bp_fe_queue_s mk_q(input logic [38:0] pc, input bp_fe_queue_type_e t);
        bp_fe_queue_s q;
        q.msg_type  = t;
        q.xcpt_code = e_itlb_miss;
        q.pc        = pc;
        q.instr     = 32'h0000_0013;
        return q;
    endfunction

    function automatic bp_fe_cmd_s mk_c(input bp_fe_cmd_opcode_e op, input logic [38:0] va);
        bp_fe_cmd_s c;
        c.opcode = op;
        c.vaddr  = va;
        return c;
    endfunction

    task automatic tick(input logic qv, input bp_fe_queue_s q, input logic cv, input bp_fe_cmd_s c,
                        input logic cy, input logic fy);
        fe_queue_v = qv; fe_queue = q; cmd_v = cv; cmd = c; fe_cmd_yumi = cy; fetch_yumi = fy;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        fe_queue_v = 0; fe_queue = NOQ; cmd_v = 0; cmd = NOC; fe_cmd_yumi = 0; fetch_yumi = 0;
        #1;
        tests++;
        if ({fe_queue_ready, fe_cmd_v, fetch_v, cmd_ready, drop_cnt, err} !== {4'b1001, 8'h00, 1'b0}) begin
            fails++;
            $display("FAIL reset_values: got %b, expected 1001_00000000_0",
                     {fe_queue_ready, fe_cmd_v, fetch_v, cmd_ready, drop_cnt, err});
        end
        @(negedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        tick(0, NOQ, 0, NOC, 0, 0);
        tests++;
        if (dut_vec() !== ref_vec()) begin
            fails++; $display("FAIL reset_idle: got %h expected %h", dut_vec(), ref_vec());
        end
    endtask

    task automatic test_state_reset();
        bp_fe_cmd_s c;
        c = mk_c(e_op_state_reset, 39'h80000000);
        tick(0, NOQ, 1, c, 0, 0);
        tests++;
        if (fe_cmd_v !== 1'b1 || fe_cmd !== c) begin
            fails++; $display("FAIL state_reset_cmd: v=%b cmd=%h, expected v=1 cmd=%h", fe_cmd_v, fe_cmd, c);
        end
        tick(0, NOQ, 0, NOC, 1, 0);
        tests++;
        if (drop_cnt !== 8'd0 || err !== 1'b0 || fe_cmd_v !== 1'b0) begin
            fails++; $display("FAIL state_reset_yumi: drop=%0d err=%b v=%b, expected 0 0 0", drop_cnt, err, fe_cmd_v);
        end
        tick(1, mk_q(39'h500, e_fe_fetch), 0, NOC, 0, 0);
        tests++;
        if (fetch_v !== 1'b1 || fetch.pc !== 39'h500) begin
            fails++; $display("FAIL run_reached: fetch_v=%b pc=%h, expected 1 500", fetch_v, fetch.pc);
        end
        tick(0, NOQ, 0, NOC, 0, 1);
        tests++;
        if (dut_vec() !== ref_vec()) begin
            fails++; $display("FAIL state_reset_drain: got %h expected %h", dut_vec(), ref_vec());
        end
    endtask

    task automatic test_fill();
        logic [38:0] exp_pc;
        for (int i = 0; i < 4; i++) begin
            tick(1, mk_q(39'h1000 + 39'(4 * i), e_fe_fetch), 0, NOC, 0, 0);
            tests++;
            if (dut_vec() !== ref_vec()) begin
                fails++; $display("FAIL fill_%0d: got %h expected %h", i, dut_vec(), ref_vec());
            end
        end
        tests++;
        if (fe_queue_ready !== 1'b0 || fetch.pc !== 39'h1000) begin
            fails++; $display("FAIL fill_full: ready=%b head=%h, expected 0 1000", fe_queue_ready, fetch.pc);
        end
        tick(1, mk_q(39'h1010, e_fe_fetch), 0, NOC, 0, 1);
        tick(1, mk_q(39'h1010, e_fe_fetch), 0, NOC, 0, 0);
        tests++;
        if (dut_vec() !== ref_vec()) begin
            fails++; $display("FAIL fill_fifth: got %h expected %h", dut_vec(), ref_vec());
        end
        for (int k = 1; k <= 4; k++) begin
            exp_pc = 39'h1000 + 39'(4 * k);
            tests++;
            if (fetch_v !== 1'b1 || fetch.pc !== exp_pc) begin
                fails++; $display("FAIL fill_order_%0d: v=%b pc=%h, expected 1 %h", k, fetch_v, fetch.pc, exp_pc);
            end
            tick(0, NOQ, 0, NOC, 0, 1);
        end
        tests++;
        if (fetch_v !== 1'b0) begin
            fails++; $display("FAIL fill_empty: fetch_v=%b, expected 0", fetch_v);
        end
    endtask

    task automatic test_exception();
        tick(1, mk_q(39'h2000, e_fe_exception), 0, NOC, 0, 0);
        tests++;
        if (dut_vec() !== ref_vec()) begin
            fails++; $display("FAIL exc_enq: got %h expected %h", dut_vec(), ref_vec());
        end
        tick(1, mk_q(39'h2004, e_fe_fetch), 0, NOC, 0, 0);
        tests++;
        if (drop_cnt !== 8'd1 || err !== 1'b1 || fetch_v !== 1'b1 ||
            fetch.msg_type !== e_fe_exception || fetch.xcpt_code !== e_itlb_miss) begin
            fails++; $display("FAIL exc_stall: drop=%0d err=%b v=%b type=%b, expected 1 1 1 1",
                              drop_cnt, err, fetch_v, fetch.msg_type);
        end
        tick(0, NOQ, 0, NOC, 0, 1);
        tests++;
        if (dut_vec() !== ref_vec()) begin
            fails++; $display("FAIL exc_drain: got %h expected %h", dut_vec(), ref_vec());
        end
    endtask

    task automatic test_redirect();
        tick(0, NOQ, 1, mk_c(e_op_state_reset, 39'h0), 0, 0);
        tick(0, NOQ, 0, NOC, 1, 0);
        for (int i = 0; i < 3; i++) tick(1, mk_q(39'h3000 + 39'(4 * i), e_fe_fetch), 0, NOC, 0, 0);
        tests++;
        if (dut_vec() !== ref_vec() || fetch_v !== 1'b1) begin
            fails++; $display("FAIL redir_buffered: got %h expected %h", dut_vec(), ref_vec());
        end
        tick(0, NOQ, 1, mk_c(e_op_pc_redirection, 39'h3100), 0, 0);
        tests++;
        if (fetch_v !== 1'b0 || fe_cmd_v !== 1'b1) begin
            fails++; $display("FAIL redir_clear: fetch_v=%b cmd_v=%b, expected 0 1", fetch_v, fe_cmd_v);
        end
        tick(1, mk_q(39'h3200, e_fe_fetch), 0, NOC, 0, 0);
        tick(1, mk_q(39'h3204, e_fe_fetch), 0, NOC, 0, 0);
        tests++;
        if (dut_vec() !== ref_vec()) begin
            fails++; $display("FAIL redir_hold: got %h expected %h", dut_vec(), ref_vec());
        end
        tick(0, NOQ, 0, NOC, 1, 0);
        tests++;
        if (drop_cnt !== 8'd3 || err !== 1'b1) begin
            fails++; $display("FAIL redir_drops: drop=%0d err=%b, expected 3 1", drop_cnt, err);
        end
        tick(1, mk_q(39'h3300, e_fe_fetch), 0, NOC, 0, 0);
        tests++;
        if (fetch_v !== 1'b1 || fetch.pc !== 39'h3300) begin
            fails++; $display("FAIL redir_run: v=%b pc=%h, expected 1 3300", fetch_v, fetch.pc);
        end
    endtask

    task automatic test_attaboy();
        tick(0, NOQ, 1, mk_c(e_op_attaboy, 39'h0), 0, 0);
        tests++;
        if (fetch_v !== 1'b1 || fe_cmd_v !== 1'b1 || fe_cmd.opcode !== e_op_attaboy) begin
            fails++; $display("FAIL atta_keep: fetch_v=%b op=%0d, expected 1 %0d", fetch_v, fe_cmd.opcode, e_op_attaboy);
        end
        tick(0, NOQ, 1, mk_c(e_op_pc_redirection, 39'h3400), 0, 0);
        tests++;
        if (fetch_v !== 1'b0 || fe_cmd.opcode !== e_op_attaboy || cmd_ready !== 1'b0) begin
            fails++; $display("FAIL atta_redir: fetch_v=%b op=%0d rdy=%b, expected 0 %0d 0",
                              fetch_v, fe_cmd.opcode, cmd_ready, e_op_attaboy);
        end
        tick(1, mk_q(39'h3500, e_fe_fetch), 0, NOC, 1, 0);
        tests++;
        if (fe_cmd.opcode !== e_op_pc_redirection || drop_cnt !== 8'd4) begin
            fails++; $display("FAIL atta_pending: op=%0d drop=%0d, expected %0d 4",
                              fe_cmd.opcode, drop_cnt, e_op_pc_redirection);
        end
        tick(0, NOQ, 0, NOC, 1, 0);
        tick(1, mk_q(39'h3600, e_fe_fetch), 0, NOC, 0, 0);
        tests++;
        if (fetch_v !== 1'b1 || fetch.pc !== 39'h3600 || dut_vec() !== ref_vec()) begin
            fails++; $display("FAIL atta_run: got %h expected %h", dut_vec(), ref_vec());
        end
        tick(0, NOQ, 0, NOC, 0, 1);
    endtask

    task automatic test_random();
        bp_fe_queue_s q;
        bp_fe_cmd_s   c;
        for (int n = 0; n < 600; n++) begin
            q.msg_type  = ($urandom_range(7) == 0) ? e_fe_exception : e_fe_fetch;
            q.xcpt_code = bp_fe_exception_code_e'($urandom_range(3));
            q.pc        = {7'd0, $urandom()};
            q.instr     = $urandom();
            c.opcode    = bp_fe_cmd_opcode_e'($urandom_range(5));
            c.vaddr     = {7'd0, $urandom()};
            tick($urandom_range(1), q, $urandom_range(2) == 0, c, $urandom_range(1), $urandom_range(1));
            tests++;
            if (dut_vec() !== ref_vec()) begin
                fails++; $display("FAIL random_%0d: got %h expected %h", n, dut_vec(), ref_vec());
            end
        end
    endtask

    task automatic test_saturation_reset();
        fe_queue_v = 0; cmd_v = 0; fe_cmd_yumi = 0; fetch_yumi = 0;
        reset_n_i = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        for (int n = 0; n < 300; n++) tick(1, mk_q(39'(n), e_fe_fetch), 0, NOC, 0, 0);
        tests++;
        if (drop_cnt !== 8'd255 || err !== 1'b1 || dut_vec() !== ref_vec()) begin
            fails++; $display("FAIL saturate: drop=%0d err=%b, expected 255 1", drop_cnt, err);
        end
        tick(0, NOQ, 1, mk_c(e_op_state_reset, 39'h0), 0, 0);
        tick(0, NOQ, 0, NOC, 1, 0);
        tick(1, mk_q(39'h4000, e_fe_fetch), 0, NOC, 0, 0);
        tick(0, NOQ, 1, mk_c(e_op_attaboy, 39'h0), 0, 0);
        tests++;
        if (fetch_v !== 1'b1 || fe_cmd_v !== 1'b1 || drop_cnt !== 8'd255) begin
            fails++; $display("FAIL pre_reset: fetch_v=%b cmd_v=%b drop=%0d, expected 1 1 255", fetch_v, fe_cmd_v, drop_cnt);
        end
        fe_queue_v = 0; cmd_v = 0; fe_cmd_yumi = 0; fetch_yumi = 0;
        #2;
        reset_n_i = 1'b0;
        #1;
        tests++;
        if ({fe_queue_ready, fe_cmd_v, fetch_v, cmd_ready, drop_cnt, err} !== {4'b1001, 8'h00, 1'b0}) begin
            fails++;
            $display("FAIL async_reset: got %b, expected 1001_00000000_0",
                     {fe_queue_ready, fe_cmd_v, fetch_v, cmd_ready, drop_cnt, err});
        end
        @(negedge clk_i);
        reset_n_i = 1'b1;
        tick(0, NOQ, 0, NOC, 0, 0);
        tests++;
        if (dut_vec() !== ref_vec()) begin
            fails++; $display("FAIL post_reset: got %h expected %h", dut_vec(), ref_vec());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_state_reset();
        test_fill();
        test_exception();
        test_redirect();
        test_attaboy();
        test_random();
        test_saturation_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
